// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: state/owner types and default tuning shared by mem_arbiter and its interface users
package mem_arbiter_pkg;
  typedef enum logic {ARB_IDLE, ARB_WAIT} arb_state_e;
  typedef enum logic {OWN_IF, OWN_LS} owner_e;
  localparam int MAX_WAIT_DEF = 4;
  localparam int TIMEOUT_DEF = 16;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, load/store and memory-side signals of mem_arbiter
// bus_err exists only when MEM_ARB_TIMEOUT_EN is defined
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic [DATA_W/8-1:0] ls_be;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W/8-1:0] mem_be;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
  logic              bus_err;
`endif
  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_be, mem_gnt, mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
`ifdef MEM_ARB_TIMEOUT_EN
    , output bus_err
`endif
  );
  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_be, mem_gnt, mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
`ifdef MEM_ARB_TIMEOUT_EN
    , input bus_err
`endif
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: LS-priority arbiter with IF starvation guard over one memory port, one transaction in flight.
// Define MEM_ARB_TIMEOUT_EN to abort a silent memory after TIMEOUT wait cycles and pulse bus_err.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
`ifdef MEM_ARB_TIMEOUT_EN
  , parameter int TIMEOUT = TIMEOUT_DEF
`endif
) (
  input logic clk,
  input logic rst_n,
  mem_arbiter_if.slave bus
);
  localparam int SW = $clog2(MAX_WAIT + 1);
  localparam logic [SW-1:0] SAT = SW'(MAX_WAIT);
  arb_state_e state, state_nxt;
  owner_e owner, sel;
  logic [SW-1:0] starve;
  logic gnt, rsp, expire;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] tmo;
  assign expire = state == ARB_WAIT && !bus.mem_rvalid && tmo == TLAST;
  assign bus.bus_err = expire;
`else
  assign expire = 1'b0;
`endif
  // rst_n gates the request so nothing leaks out while reset is held
  always_comb begin
    sel = bus.ls_req && (!bus.if_req || starve < SAT) ? OWN_LS : OWN_IF;
    bus.mem_req = rst_n && state == ARB_IDLE && (bus.if_req || bus.ls_req);
    gnt = bus.mem_req && bus.mem_gnt;
    bus.if_gnt = gnt && sel == OWN_IF;
    bus.ls_gnt = gnt && sel == OWN_LS;
    bus.mem_we = bus.mem_req && sel == OWN_LS && bus.ls_we;
    bus.mem_addr = !bus.mem_req ? '0 : sel == OWN_LS ? bus.ls_addr : bus.if_addr;
    bus.mem_wdata = bus.mem_req && sel == OWN_LS ? bus.ls_wdata : '0;
    bus.mem_be = !bus.mem_req ? '0 : sel == OWN_LS ? bus.ls_be : '1;
    rsp = state == ARB_WAIT && (bus.mem_rvalid || expire);
    bus.if_rvalid = rsp && owner == OWN_IF;
    bus.ls_rvalid = rsp && owner == OWN_LS;
    bus.if_rdata = expire ? '0 : bus.mem_rdata;
    bus.ls_rdata = bus.if_rdata;
    state_nxt = gnt ? ARB_WAIT : rsp ? ARB_IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ARB_IDLE;
      owner <= OWN_IF;
      starve <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      tmo <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (gnt) owner <= sel;
      if (bus.if_gnt || (state == ARB_IDLE && !bus.if_req)) starve <= '0;
      else if (bus.ls_gnt && bus.if_req && starve != SAT) starve <= starve + 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
      tmo <= gnt ? '0 : state == ARB_WAIT ? tmo + 1'b1 : tmo;
`endif
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic checked every cycle against a behavioural model
module tb_mem_arbiter;
  localparam int MW = 4;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TO = 16;
`endif
  logic clk = 0, rst_n = 0;
  int n_chk = 0, n_fail = 0;
  bit m_busy, m_ls, m_we, e_ifg, e_lsg, sel_ls, e_req, rsp, tmo;
  int m_streak, m_wait, lat_left;
  bit mute, rand_lat, spur_en, inject, rsp_fixed;
  logic [31:0] rsp_val;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  mem_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: memory is free or holds one transaction for a known owner; streak = LS wins while IF waited
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_mem_req", bus.mem_req, 0);
      chk("rst_if_gnt", bus.if_gnt, 0);
      chk("rst_ls_gnt", bus.ls_gnt, 0);
      chk("rst_if_rvalid", bus.if_rvalid, 0);
      chk("rst_ls_rvalid", bus.ls_rvalid, 0);
      m_busy = 0; m_streak = 0; m_wait = 0; e_ifg = 0; e_lsg = 0;
    end else begin
      sel_ls = bus.ls_req && (!bus.if_req || m_streak < MW);
      e_req = !m_busy && (bus.if_req || bus.ls_req);
      e_ifg = e_req && bus.mem_gnt && !sel_ls;
      e_lsg = e_req && bus.mem_gnt && sel_ls;
      tmo = 0;
`ifdef MEM_ARB_TIMEOUT_EN
      tmo = m_busy && !bus.mem_rvalid && m_wait == TO - 1;
      chk("bus_err", bus.bus_err, tmo);
`endif
      rsp = m_busy && (bus.mem_rvalid || tmo);
      chk("mem_req", bus.mem_req, e_req);
      chk("if_gnt", bus.if_gnt, e_ifg);
      chk("ls_gnt", bus.ls_gnt, e_lsg);
      chk("if_rvalid", bus.if_rvalid, rsp && !m_ls);
      chk("ls_rvalid", bus.ls_rvalid, rsp && m_ls);
      if (e_req) begin
        chk("mem_addr", bus.mem_addr, sel_ls ? bus.ls_addr : bus.if_addr);
        chk("mem_we", bus.mem_we, sel_ls && bus.ls_we);
        chk("mem_be", bus.mem_be, sel_ls ? {28'd0, bus.ls_be} : 32'hF);
        if (sel_ls && bus.ls_we) chk("mem_wdata", bus.mem_wdata, bus.ls_wdata);
      end
      if (rsp && !m_ls) chk("if_rdata", bus.if_rdata, tmo ? 32'd0 : bus.mem_rdata);
      if (rsp && m_ls && !m_we) chk("ls_rdata", bus.ls_rdata, tmo ? 32'd0 : bus.mem_rdata);
      if (e_ifg) m_streak = 0;
      else if (!m_busy && !bus.if_req) m_streak = 0;
      else if (e_lsg && bus.if_req && m_streak < MW) m_streak++;
      if (e_ifg || e_lsg) begin
        m_busy = 1; m_ls = e_lsg; m_we = e_lsg && bus.ls_we; m_wait = 0;
      end else if (rsp) m_busy = 0;
      else if (m_busy) m_wait++;
    end
  end

  // memory responder: answers each predicted grant after lat_left wait cycles
  initial begin
    bus.mem_rvalid = 0; bus.mem_rdata = 0; lat_left = 0;
    forever begin
      @(posedge clk); #2;
      bus.mem_rvalid = 0;
      bus.mem_rdata = $urandom;
      if (!rst_n) lat_left = 0;
      else begin
        if (e_ifg || e_lsg) lat_left = rand_lat ? int'($urandom_range(1, 3)) : 1;
        if (lat_left > 0) begin
          lat_left--;
          if (lat_left == 0 && !mute) begin
            bus.mem_rvalid = 1;
            if (rsp_fixed) bus.mem_rdata = rsp_val;
          end
        end else if (inject || (spur_en && !m_busy && $urandom_range(0, 99) < 15)) bus.mem_rvalid = 1;
      end
    end
  end

  task automatic count_ls(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.if_gnt) return;
      if (bus.ls_gnt) n++;
    end
    n = -1;
  endtask

  initial begin
    int n;
    bus.if_req = 1; bus.if_addr = 0; bus.ls_req = 0; bus.ls_we = 0; bus.ls_addr = 0;
    bus.ls_wdata = 0; bus.ls_be = 0; bus.mem_gnt = 1;
    mute = 0; rand_lat = 0; spur_en = 0; inject = 0; rsp_fixed = 1; rsp_val = 32'h00500093;
    repeat (3) @(negedge clk);
    chk("reset_hold_mem_req", bus.mem_req, 0);
    chk("reset_hold_if_gnt", bus.if_gnt, 0);
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    chk("first_if_gnt", bus.if_gnt, 1);
    chk("first_mem_addr", bus.mem_addr, 0);
    @(posedge clk); #1 bus.if_req = 0;
    @(negedge clk); chk("first_if_rvalid", bus.if_rvalid, 1);
    // single fetch
    @(posedge clk); #1 bus.if_req = 1; bus.if_addr = 32'h4;
    @(negedge clk); chk("fetch_gnt", bus.if_gnt, 1); chk("fetch_addr", bus.mem_addr, 32'h4);
    @(posedge clk); #1 bus.if_req = 0;
    @(negedge clk);
    chk("fetch_rvalid", bus.if_rvalid, 1);
    chk("fetch_rdata", bus.if_rdata, 32'h00500093);
    chk("fetch_ls_quiet", bus.ls_rvalid, 0);
    // contention
    @(posedge clk); #1 bus.if_req = 1; bus.if_addr = 32'h8; bus.ls_req = 1; bus.ls_we = 0; bus.ls_addr = 32'h100;
    @(negedge clk);
    chk("cont_ls_first", bus.ls_gnt, 1);
    chk("cont_if_held", bus.if_gnt, 0);
    chk("cont_addr", bus.mem_addr, 32'h100);
    @(posedge clk); #1 bus.ls_req = 0;
    @(negedge clk);
    chk("cont_ls_rvalid", bus.ls_rvalid, 1);
    chk("cont_ls_rdata", bus.ls_rdata, 32'h00500093);
    @(negedge clk);
    chk("cont_if_gnt", bus.if_gnt, 1);
    chk("cont_if_addr", bus.mem_addr, 32'h8);
    @(posedge clk); #1 bus.if_req = 0;
    @(negedge clk); chk("cont_if_rvalid", bus.if_rvalid, 1);
    // starvation guard, twice to show the count restarts after the IF grant
    @(posedge clk); #1 bus.if_req = 1; bus.if_addr = 32'hC; bus.ls_req = 1; bus.ls_addr = 32'h104;
    count_ls(n); chk("starve_ls_grants", n, MW);
    @(posedge clk); #1 bus.if_addr = 32'h10;
    count_ls(n); chk("starve_after_clear", n, MW);
    @(posedge clk); #1 bus.if_req = 0; bus.ls_req = 0;
    @(negedge clk);
    // store ack, then a stray response while idle
    @(posedge clk); #1 bus.ls_req = 1; bus.ls_we = 1; bus.ls_addr = 32'h200;
    bus.ls_wdata = 32'hDEADBEEF; bus.ls_be = 4'b0011;
    @(negedge clk);
    chk("store_gnt", bus.ls_gnt, 1);
    chk("store_we", bus.mem_we, 1);
    chk("store_be", bus.mem_be, 4'b0011);
    chk("store_wdata", bus.mem_wdata, 32'hDEADBEEF);
    @(posedge clk); #1 bus.ls_req = 0; bus.ls_we = 0;
    @(negedge clk); chk("store_ack", bus.ls_rvalid, 1); chk("store_if_quiet", bus.if_rvalid, 0);
    @(posedge clk); #1 inject = 1; #2 inject = 0;
    @(negedge clk); chk("stray_if_rvalid", bus.if_rvalid, 0); chk("stray_ls_rvalid", bus.ls_rvalid, 0);
    // reset while waiting drops the transaction; a late response is ignored
    @(posedge clk); #1 mute = 1; bus.if_req = 1; bus.if_addr = 32'h40;
    @(negedge clk); chk("rw_gnt", bus.if_gnt, 1);
    @(posedge clk); #1 bus.if_req = 0;
    @(posedge clk); #1 rst_n = 0; bus.if_req = 1; bus.if_addr = 32'h44;
    @(negedge clk); chk("rw_reset_mem_req", bus.mem_req, 0);
    @(posedge clk); #1 rst_n = 1; mute = 0; inject = 1; #2 inject = 0;
    @(negedge clk);
    chk("late_if_rvalid", bus.if_rvalid, 0);
    chk("post_reset_gnt", bus.if_gnt, 1);
    chk("post_reset_addr", bus.mem_addr, 32'h44);
    @(posedge clk); #1 bus.if_req = 0;
    @(negedge clk);
`ifdef MEM_ARB_TIMEOUT_EN
    @(posedge clk); #1 mute = 1; bus.if_req = 1; bus.if_addr = 32'h80;
    @(negedge clk); chk("to_gnt", bus.if_gnt, 1);
    @(posedge clk); #1 bus.if_req = 0;
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.bus_err) begin
        n = i;
        chk("to_if_rvalid", bus.if_rvalid, 1);
        chk("to_if_rdata", bus.if_rdata, 0);
        break;
      end
    end
    chk("to_cycles", n, TO);
    mute = 0;
    @(posedge clk); #1 bus.if_req = 1; bus.if_addr = 32'h84;
    @(negedge clk); chk("to_pulse_once", bus.bus_err, 0); chk("to_back_idle", bus.if_gnt, 1);
    @(posedge clk); #1 bus.if_req = 0;
    @(negedge clk);
`endif
    // randomized traffic; requesters hold until granted
    rand_lat = 1; spur_en = 1; rsp_fixed = 0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      if (!bus.if_req || e_ifg) begin
        bus.if_req = $urandom_range(0, 99) < 55;
        bus.if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!bus.ls_req || e_lsg) begin
        bus.ls_req = $urandom_range(0, 99) < 65;
        bus.ls_we = 1'($urandom_range(0, 1));
        bus.ls_addr = $urandom;
        bus.ls_wdata = $urandom;
        bus.ls_be = 4'($urandom);
      end
      bus.mem_gnt = $urandom_range(0, 3) != 0;
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
